// File: rtl/sum_scheduler.sv
// sum_scheduler: two-channel block-mean accumulator sharing one external
// 20+20->21 adder. Samples are granted round-robin, one per cycle, while the
// block is running; every 2**LOG2N accepted samples of a channel produce one
// mean on the m_* handshake.
// Build option: define SUM_SAT_EN to saturate accumulation at 20'hFFFFF and
// record a sticky per-channel overflow flag; otherwise sums wrap and ovf is 0.
module sum_scheduler #(
    parameter int LOG2N = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [19:0] s0_data,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [19:0] s1_data,
    input  logic        s1_valid,
    output logic        s1_ready,
    output logic [19:0] add_a,
    output logic [19:0] add_b,
    input  logic [20:0] add_s,
    output logic [19:0] m_data,
    output logic        m_ch,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic [1:0]  ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [19:0]      r_acc [2];
    logic [LOG2N-1:0] r_cnt [2];
    logic             r_ptr;
    logic [19:0]      r_m_data;
    logic             r_m_ch;
    logic             r_m_valid;

    logic [1:0]       w_valid;
    logic [19:0]      w_data [2];
    logic [1:0]       w_last;
    logic [1:0]       w_elig;
    logic [1:0]       w_grant;
    logic             w_gch;
    logic             w_accept;
    logic             w_done;
    logic             w_out_block;
    logic             w_out_fire;
    logic             w_enter_run;
    logic             w_stop_run;
    logic [19:0]      w_result;

    assign w_valid[0] = s0_valid;
    assign w_valid[1] = s1_valid;
    assign w_data[0]  = s0_data;
    assign w_data[1]  = s1_data;

    // Output slot is stuck when a result waits and the sink refuses it.
    assign w_out_block = r_m_valid & ~m_ready;
    assign w_out_fire  = r_m_valid & m_ready;
    assign w_stop_run  = (r_state == ST_RUN) && stop;

    // A channel about to complete a block may only go when the output slot
    // will be free this cycle; otherwise its completion would be lost.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            assign w_last[gi] = (r_cnt[gi] == {LOG2N{1'b1}});
            assign w_elig[gi] = (r_state == ST_RUN) && w_valid[gi]
                                && !(w_last[gi] && w_out_block);
        end
    endgenerate

    // Round-robin arbiter: pointer channel wins a tie, otherwise whoever is eligible.
    always_comb begin
        w_grant = 2'b00;
        w_gch   = 1'b0;
        if (w_elig[0] && w_elig[1]) begin
            w_gch          = r_ptr;
            w_grant[r_ptr] = 1'b1;
        end else if (w_elig[0]) begin
            w_gch      = 1'b0;
            w_grant[0] = 1'b1;
        end else if (w_elig[1]) begin
            w_gch      = 1'b1;
            w_grant[1] = 1'b1;
        end
    end

    assign w_accept = |w_grant;
    assign w_done   = w_accept && w_last[w_gch];
    assign s0_ready = w_grant[0];
    assign s1_ready = w_grant[1];
    assign add_a    = w_accept ? r_acc[w_gch]  : 20'd0;
    assign add_b    = w_accept ? w_data[w_gch] : 20'd0;

`ifdef SUM_SAT_EN
    logic [1:0] r_ovf;

    // Clamp the shared adder result when it carries out.
    always_comb begin
        w_result = add_s[19:0];
        if (add_s[20]) begin
            w_result = 20'hFFFFF;
        end
    end

    // Sticky overflow per channel, cleared only when a new run begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 2'b00;
        end else if (w_enter_run) begin
            r_ovf <= 2'b00;
        end else if (w_accept && add_s[20]) begin
            r_ovf[w_gch] <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_carry;

    // Plain wrap-around accumulation; the carry out is deliberately dropped.
    always_comb begin
        w_result = add_s[19:0];
    end

    assign w_unused_carry = add_s[20];
    assign ovf            = 2'b00;
`endif

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start beats stop in IDLE; DRAIN waits for the output slot to empty.
    always_comb begin
        w_state_next = r_state;
        w_enter_run  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_enter_run  = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_m_valid || m_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    // Accumulators and block counters; a new run or a stop throws partial blocks away.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst_n || w_enter_run || w_stop_run) begin
                r_acc[c] <= 20'd0;
                r_cnt[c] <= '0;
            end else if (w_grant[c]) begin
                if (w_last[c]) begin
                    r_acc[c] <= 20'd0;
                    r_cnt[c] <= '0;
                end else begin
                    r_acc[c] <= w_result;
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    // Fairness pointer hands priority to the channel that was not just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_gch;
        end
    end

    // Result register: a completion reloads it even while the old result is being taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_data  <= 20'd0;
            r_m_ch    <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_done) begin
            r_m_data  <= w_result >> LOG2N;
            r_m_ch    <= w_gch;
            r_m_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_data  = r_m_data;
    assign m_ch    = r_m_ch;
    assign m_valid = r_m_valid;

endmodule
